uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync2.sv | 26 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default bit timing and
// counter widths used by both the transmitter and the receiver.
package uart_pkg;

    // Clocks per bit; matches the transmitter's 0xA2C+1 bit period.
    localparam int BAUD_CYCLES_DEFAULT = 2605;
    // Clocks from the detected start edge to the start-bit mid-sample.
    localparam int HALF_CYCLES_DEFAULT = 1302;

    localparam int BAUD_CNT_W   = 12;
    localparam int BIT_CNT_W    = 4;
    // Start + 8 data + stop samples per frame.
    localparam int FRAME_SHIFTS = 10;

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } uart_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous input. Both stages reset to 1
// so an idle-high line never looks like a falling edge coming out of reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Shift the raw input through two flops before anyone looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, one stop bit, no parity.
// A start is taken whenever the synchronized line is low in IDLE; each bit
// is sampled at its middle by a down-counting baud counter. rdy is sticky
// until clr_rdy or the next start, and frm_err qualifies it.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_CYCLES = BAUD_CYCLES_DEFAULT,
    parameter int HALF_CYCLES = HALF_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    localparam logic [BAUD_CNT_W-1:0] HALF_LOAD = BAUD_CNT_W'(HALF_CYCLES);
    localparam logic [BAUD_CNT_W-1:0] BAUD_LOAD = BAUD_CNT_W'(BAUD_CYCLES - 1);
    localparam logic [BIT_CNT_W-1:0]  START_IDX = '0;
    localparam logic [BIT_CNT_W-1:0]  STOP_IDX  = BIT_CNT_W'(FRAME_SHIFTS - 1);

    logic                  rx_s;

    uart_state_t           state_reg;
    uart_state_t           state_next;
    logic [BAUD_CNT_W-1:0] baud_cnt_reg;
    logic [BAUD_CNT_W-1:0] baud_cnt_next;
    logic [BIT_CNT_W-1:0]  bit_cnt_reg;
    logic [BIT_CNT_W-1:0]  bit_cnt_next;
    logic [8:0]            rx_shft_reg;
    logic [8:0]            rx_shft_next;
    logic                  rdy_reg;
    logic                  rdy_next;
    logic                  frm_err_reg;
    logic                  frm_err_next;
    logic                  shift;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (RX),
        .q     (rx_s)
    );

    // One sample per bit: the baud counter has run out while receiving.
    assign shift = (state_reg == RECEIVE) && (baud_cnt_reg == '0);

    // State and datapath registers; everything returns to idle on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            rx_shft_reg  <= '0;
            rdy_reg      <= 1'b0;
            frm_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            rx_shft_reg  <= rx_shft_next;
            rdy_reg      <= rdy_next;
            frm_err_reg  <= frm_err_next;
        end
    end

    // Next-state logic: start detection, bit timing, sampling and the
    // rdy/frm_err flags. The clear is applied first so a frame completing
    // on the same clock overrides it.
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        rx_shft_next  = rx_shft_reg;
        rdy_next      = rdy_reg;
        frm_err_next  = frm_err_reg;

        if (clr_rdy) begin
            rdy_next     = 1'b0;
            frm_err_next = 1'b0;
        end

        unique case (state_reg)
            IDLE: begin
                // A low line in IDLE is a start, even right after a frame
                // ends, so back-to-back frames with a single stop bit work.
                if (!rx_s) begin
                    baud_cnt_next = HALF_LOAD;
                    bit_cnt_next  = '0;
                    rdy_next      = 1'b0;
                    frm_err_next  = 1'b0;
                    state_next    = RECEIVE;
                end
            end

            RECEIVE: begin
                if (shift) begin
                    baud_cnt_next = BAUD_LOAD;
                    bit_cnt_next  = bit_cnt_reg + 1'b1;
                    rx_shft_next  = {rx_s, rx_shft_reg[8:1]};
                    if ((bit_cnt_reg == START_IDX) && rx_s) begin
                        // Line was high again at start mid-bit: glitch.
                        state_next = IDLE;
                    end else if (bit_cnt_reg == STOP_IDX) begin
                        state_next   = IDLE;
                        rdy_next     = 1'b1;
                        frm_err_next = ~rx_s;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // After the stop bit has shifted in, the data byte sits in the low bits.
    assign rx_data = rx_shft_reg[7:0];
    assign rdy     = rdy_reg;
    assign frm_err = frm_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Frames are serialized from bytes by the
// bench; the expected result of each frame (byte, ~stop, spec latency) is
// queued when the frame is sent and matched against rdy rising edges.
module tb_uart_rx;

    localparam int BAUD = 40;
    localparam int HALF = 19;
    // RX falling edge to rdy rising: 2 sync + HALF+1 + 9 bit periods.
    localparam int LAT = 2 + HALF + 1 + 9 * BAUD;
    // A low stop bit is cut short so the line is high again by the time the
    // receiver's automatic restart reaches its start mid-sample.
    localparam int STOP0_LEN = 30;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       RX      = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    int checks   = 0;
    int fails    = 0;
    int cyc      = 0;
    int lat_meas = LAT + 1;

    logic [7:0] ev_data[$];
    logic       ev_frm[$];
    int         ev_cyc[$];
    logic [7:0] exp_data[$];
    logic       exp_frm[$];
    int         exp_fall[$];
    logic       rdy_q = 1'b0;

    uart_rx #(
        .BAUD_CYCLES (BAUD),
        .HALF_CYCLES (HALF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every rdy rising edge together with the byte and error flag.
    always @(negedge clk) begin
        if (rdy === 1'b1 && rdy_q !== 1'b1) begin
            ev_data.push_back(rx_data);
            ev_frm.push_back(frm_err);
            ev_cyc.push_back(cyc);
        end
        rdy_q <= rdy;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_queues();
        ev_data.delete();  ev_frm.delete();  ev_cyc.delete();
        exp_data.delete(); exp_frm.delete(); exp_fall.delete();
    endtask

    // Serialize one frame (start, 8 data LSB first, stop) and queue its
    // expected outcome. Caller must be 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_data.push_back(d);
        exp_frm.push_back(~stop);
        exp_fall.push_back(cyc);
        RX = 1'b0;
        wait_cycles(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            wait_cycles(BAUD);
        end
        RX = stop;
        wait_cycles(stop ? BAUD : STOP0_LEN);
        RX = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rdy !== 1'b0 || frm_err !== 1'b0 || rx_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_async: rdy=%b frm_err=%b rx_data=%h, required 0 0 00", rdy, frm_err, rx_data);
        end
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2 * BAUD);
        checks++;
        if (rdy !== 1'b0 || frm_err !== 1'b0 || rx_data !== 8'h00 || ev_data.size() != 0) begin
            fails++;
            $display("FAIL reset_idle: rdy=%b frm_err=%b rx_data=%h events=%0d, required 0 0 00 0",
                     rdy, frm_err, rx_data, ev_data.size());
        end
        $display("reset: rdy=%b frm_err=%b rx_data=%h", rdy, frm_err, rx_data);
        clear_queues();
    endtask

    task automatic test_single();
        logic [7:0] gd, ed;
        logic gf, ef;
        int c, f0;
        send_frame(8'hA5, 1'b1);
        wait_cycles(4);
        checks++;
        if (ev_data.size() != 1) begin
            fails++;
            $display("FAIL single_count: %0d frames, required 1", ev_data.size());
        end
        if (ev_cyc.size() > 0 && exp_fall.size() > 0) begin
            c = ev_cyc[0] - exp_fall[0];
            if (c >= LAT - 1 && c <= LAT + 1) lat_meas = c;
        end
        while (ev_data.size() > 0 && exp_data.size() > 0) begin
            gd = ev_data.pop_front();  gf = ev_frm.pop_front();  c  = ev_cyc.pop_front();
            ed = exp_data.pop_front(); ef = exp_frm.pop_front(); f0 = exp_fall.pop_front();
            checks += 3;
            if (gd !== ed) begin fails++; $display("FAIL single_data: rx_data=%h required %h", gd, ed); end
            if (gf !== ef) begin fails++; $display("FAIL single_frm_err: frm_err=%b required %b", gf, ef); end
            if (c - f0 < LAT - 1 || c - f0 > LAT + 1) begin
                fails++; $display("FAIL single_latency: %0d clocks, required %0d..%0d", c - f0, LAT - 1, LAT + 1);
            end
            $display("single: rx_data=%h frm_err=%b latency=%0d", gd, gf, c - f0);
        end
        clr_rdy = 1'b1;
        wait_cycles(1);
        clr_rdy = 1'b0;
        checks++;
        if (rdy !== 1'b0 || frm_err !== 1'b0) begin
            fails++;
            $display("FAIL single_clr: rdy=%b frm_err=%b, required 0 0", rdy, frm_err);
        end
        clear_queues();
    endtask

    task automatic test_back_to_back();
        logic [7:0] gd, ed;
        logic gf, ef;
        int c, f0;
        bit found;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
                send_frame(8'h5A, 1'b1);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    found = 1'b0;
                    for (int t = 0; t < 12 * BAUD && !found; t++) begin
                        @(negedge clk);
                        if (rdy === 1'b1) found = 1'b1;
                    end
                    checks++;
                    if (!found) begin
                        fails++;
                        $display("FAIL b2b_timeout: frame %0d rdy=%b, required 1 within %0d clocks", k, rdy, 12 * BAUD);
                    end
                    @(posedge clk); #1;
                    clr_rdy = 1'b1;
                    @(posedge clk); #1;
                    clr_rdy = 1'b0;
                    checks++;
                    if (rdy !== 1'b0 || frm_err !== 1'b0) begin
                        fails++;
                        $display("FAIL b2b_clr: frame %0d rdy=%b frm_err=%b, required 0 0", k, rdy, frm_err);
                    end
                end
            end
        join
        wait_cycles(4);
        checks++;
        if (ev_data.size() != 3) begin
            fails++;
            $display("FAIL b2b_count: %0d frames, required 3", ev_data.size());
        end
        while (ev_data.size() > 0 && exp_data.size() > 0) begin
            gd = ev_data.pop_front();  gf = ev_frm.pop_front();  c  = ev_cyc.pop_front();
            ed = exp_data.pop_front(); ef = exp_frm.pop_front(); f0 = exp_fall.pop_front();
            checks += 3;
            if (gd !== ed) begin fails++; $display("FAIL b2b_data: rx_data=%h required %h", gd, ed); end
            if (gf !== ef) begin fails++; $display("FAIL b2b_frm_err: frm_err=%b required %b", gf, ef); end
            if (c - f0 < LAT - 1 || c - f0 > LAT + 1) begin
                fails++; $display("FAIL b2b_latency: %0d clocks, required %0d..%0d", c - f0, LAT - 1, LAT + 1);
            end
            $display("b2b: rx_data=%h frm_err=%b latency=%0d", gd, gf, c - f0);
        end
        clear_queues();
    endtask

    task automatic test_false_start();
        logic [7:0] gd, ed;
        logic gf, ef;
        int c, f0;
        // Low for well under half a bit: gone by the start mid-sample.
        RX = 1'b0;
        wait_cycles(15);
        RX = 1'b1;
        wait_cycles(3 * BAUD);
        checks++;
        if (ev_data.size() != 0 || rdy !== 1'b0 || frm_err !== 1'b0) begin
            fails++;
            $display("FAIL false_start: events=%0d rdy=%b frm_err=%b, required 0 0 0", ev_data.size(), rdy, frm_err);
        end
        $display("false_start: events=%0d rdy=%b", ev_data.size(), rdy);
        send_frame(8'h3C, 1'b1);
        wait_cycles(4);
        checks++;
        if (ev_data.size() != 1) begin
            fails++;
            $display("FAIL false_start_count: %0d frames, required 1", ev_data.size());
        end
        while (ev_data.size() > 0 && exp_data.size() > 0) begin
            gd = ev_data.pop_front();  gf = ev_frm.pop_front();  c  = ev_cyc.pop_front();
            ed = exp_data.pop_front(); ef = exp_frm.pop_front(); f0 = exp_fall.pop_front();
            checks += 3;
            if (gd !== ed) begin fails++; $display("FAIL false_start_data: rx_data=%h required %h", gd, ed); end
            if (gf !== ef) begin fails++; $display("FAIL false_start_frm_err: frm_err=%b required %b", gf, ef); end
            if (c - f0 < LAT - 1 || c - f0 > LAT + 1) begin
                fails++; $display("FAIL false_start_latency: %0d clocks, required %0d..%0d", c - f0, LAT - 1, LAT + 1);
            end
            $display("after_glitch: rx_data=%h frm_err=%b latency=%0d", gd, gf, c - f0);
        end
        clear_queues();
    endtask

    task automatic test_framing();
        logic [7:0] gd, ed;
        logic gf, ef;
        int c, f0;
        send_frame(8'h81, 1'b0);
        wait_cycles(4);
        checks++;
        if (ev_data.size() != 1) begin
            fails++;
            $display("FAIL framing_count: %0d frames, required 1", ev_data.size());
        end
        while (ev_data.size() > 0 && exp_data.size() > 0) begin
            gd = ev_data.pop_front();  gf = ev_frm.pop_front();  c  = ev_cyc.pop_front();
            ed = exp_data.pop_front(); ef = exp_frm.pop_front(); f0 = exp_fall.pop_front();
            checks += 3;
            if (gd !== ed) begin fails++; $display("FAIL framing_data: rx_data=%h required %h", gd, ed); end
            if (gf !== ef) begin fails++; $display("FAIL framing_frm_err: frm_err=%b required %b", gf, ef); end
            if (c - f0 < LAT - 1 || c - f0 > LAT + 1) begin
                fails++; $display("FAIL framing_latency: %0d clocks, required %0d..%0d", c - f0, LAT - 1, LAT + 1);
            end
            $display("framing: rx_data=%h frm_err=%b latency=%0d", gd, gf, c - f0);
        end
        wait_cycles(2 * BAUD);
        clr_rdy = 1'b1;
        wait_cycles(1);
        clr_rdy = 1'b0;
        checks++;
        if (rdy !== 1'b0 || frm_err !== 1'b0) begin
            fails++;
            $display("FAIL framing_clr: rdy=%b frm_err=%b, required 0 0", rdy, frm_err);
        end
        clear_queues();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] gd, ed;
        logic gf, ef;
        int c, f0;
        logic [7:0] d;
        d = 8'hC3;
        RX = 1'b0;
        wait_cycles(BAUD);
        for (int i = 0; i < 4; i++) begin
            RX = d[i];
            wait_cycles(BAUD);
        end
        RX = d[4];
        wait_cycles(BAUD / 2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rdy !== 1'b0 || frm_err !== 1'b0 || rx_data !== 8'h00) begin
            fails++;
            $display("FAIL midframe_reset: rdy=%b frm_err=%b rx_data=%h, required 0 0 00", rdy, frm_err, rx_data);
        end
        RX = 1'b1;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(12 * BAUD);
        checks++;
        if (ev_data.size() != 0 || rdy !== 1'b0) begin
            fails++;
            $display("FAIL midframe_abandon: events=%0d rdy=%b, required 0 0", ev_data.size(), rdy);
        end
        $display("midframe_reset: events=%0d rdy=%b", ev_data.size(), rdy);
        clear_queues();
        send_frame(d, 1'b1);
        wait_cycles(4);
        checks++;
        if (ev_data.size() != 1) begin
            fails++;
            $display("FAIL midframe_count: %0d frames, required 1", ev_data.size());
        end
        while (ev_data.size() > 0 && exp_data.size() > 0) begin
            gd = ev_data.pop_front();  gf = ev_frm.pop_front();  c  = ev_cyc.pop_front();
            ed = exp_data.pop_front(); ef = exp_frm.pop_front(); f0 = exp_fall.pop_front();
            checks += 3;
            if (gd !== ed) begin fails++; $display("FAIL midframe_data: rx_data=%h required %h", gd, ed); end
            if (gf !== ef) begin fails++; $display("FAIL midframe_frm_err: frm_err=%b required %b", gf, ef); end
            if (c - f0 < LAT - 1 || c - f0 > LAT + 1) begin
                fails++; $display("FAIL midframe_latency: %0d clocks, required %0d..%0d", c - f0, LAT - 1, LAT + 1);
            end
            $display("after_reset: rx_data=%h frm_err=%b latency=%0d", gd, gf, c - f0);
        end
        clear_queues();
    endtask

    // Line already low when reset is released: that counts as a start.
    task automatic test_reset_low_release();
        logic [7:0] gd, ed;
        logic gf, ef;
        int c, f0;
        logic [7:0] d;
        d = 8'($urandom);
        RX = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rdy !== 1'b0 || frm_err !== 1'b0) begin
            fails++;
            $display("FAIL low_release_reset: rdy=%b frm_err=%b, required 0 0", rdy, frm_err);
        end
        wait_cycles(3);
        rst_n = 1'b1;
        send_frame(d, 1'b1);
        wait_cycles(4);
        checks++;
        if (ev_data.size() != 1) begin
            fails++;
            $display("FAIL low_release_count: %0d frames, required 1", ev_data.size());
        end
        while (ev_data.size() > 0 && exp_data.size() > 0) begin
            gd = ev_data.pop_front();  gf = ev_frm.pop_front();  c  = ev_cyc.pop_front();
            ed = exp_data.pop_front(); ef = exp_frm.pop_front(); f0 = exp_fall.pop_front();
            checks += 3;
            if (gd !== ed) begin fails++; $display("FAIL low_release_data: rx_data=%h required %h", gd, ed); end
            if (gf !== ef) begin fails++; $display("FAIL low_release_frm_err: frm_err=%b required %b", gf, ef); end
            if (c - f0 < LAT - 1 || c - f0 > LAT + 1) begin
                fails++; $display("FAIL low_release_latency: %0d clocks, required %0d..%0d", c - f0, LAT - 1, LAT + 1);
            end
            $display("low_release: rx_data=%h frm_err=%b latency=%0d", gd, gf, c - f0);
        end
        clear_queues();
    endtask

    // clr_rdy held across the clock on which the frame completes.
    task automatic test_collision();
        logic [7:0] gd, ed;
        logic gf, ef;
        int c, f0;
        logic [7:0] d;
        d = 8'($urandom);
        fork
            send_frame(d, 1'b1);
            begin
                wait_cycles(lat_meas - 3);
                clr_rdy = 1'b1;
                wait_cycles(3);
                clr_rdy = 1'b0;
                checks++;
                if (rdy !== 1'b1) begin
                    fails++;
                    $display("FAIL collision_rdy: rdy=%b after clr on set clock, required 1", rdy);
                end
            end
        join
        wait_cycles(4);
        checks++;
        if (ev_data.size() != 1) begin
            fails++;
            $display("FAIL collision_count: %0d frames, required 1", ev_data.size());
        end
        while (ev_data.size() > 0 && exp_data.size() > 0) begin
            gd = ev_data.pop_front();  gf = ev_frm.pop_front();  c  = ev_cyc.pop_front();
            ed = exp_data.pop_front(); ef = exp_frm.pop_front(); f0 = exp_fall.pop_front();
            checks += 2;
            if (gd !== ed) begin fails++; $display("FAIL collision_data: rx_data=%h required %h", gd, ed); end
            if (gf !== ef) begin fails++; $display("FAIL collision_frm_err: frm_err=%b required %b", gf, ef); end
            $display("collision: rx_data=%h frm_err=%b rdy=%b", gd, gf, rdy);
        end
        clear_queues();
    endtask

    // Random bytes and stop bits, mostly back to back, with clr_rdy
    // pulsed at random while frames are in flight.
    task automatic test_random();
        logic [7:0] gd, ed;
        logic gf, ef;
        int c, f0;
        logic [7:0] d;
        logic s;
        bit done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    d = 8'($urandom);
                    s = ($urandom_range(0, 4) != 0);
                    send_frame(d, s);
                    if (!s) wait_cycles(BAUD + int'($urandom_range(0, BAUD)));
                    else    wait_cycles(int'($urandom_range(0, 2)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    clr_rdy = ($urandom_range(0, 7) == 0);
                end
                clr_rdy = 1'b0;
            end
        join
        wait_cycles(4);
        checks++;
        if (ev_data.size() != exp_data.size()) begin
            fails++;
            $display("FAIL random_count: %0d frames, required %0d", ev_data.size(), exp_data.size());
        end
        while (ev_data.size() > 0 && exp_data.size() > 0) begin
            gd = ev_data.pop_front();  gf = ev_frm.pop_front();  c  = ev_cyc.pop_front();
            ed = exp_data.pop_front(); ef = exp_frm.pop_front(); f0 = exp_fall.pop_front();
            checks += 3;
            if (gd !== ed) begin fails++; $display("FAIL random_data: rx_data=%h required %h", gd, ed); end
            if (gf !== ef) begin fails++; $display("FAIL random_frm_err: frm_err=%b required %b", gf, ef); end
            if (c - f0 < LAT - 1 || c - f0 > LAT + 1) begin
                fails++; $display("FAIL random_latency: %0d clocks, required %0d..%0d", c - f0, LAT - 1, LAT + 1);
            end
            $display("random: rx_data=%h frm_err=%b latency=%0d", gd, gf, c - f0);
        end
        clear_queues();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_framing();
        test_reset_midframe();
        test_reset_low_release();
        test_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
